// File: rtl/axi_slice_dc_pkg.sv
// rtl/axi_slice_dc_pkg.sv - shared types for the AXI slice drain/isolate controller
package axi_slice_dc_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DRAIN    = 2'd1,
    ISOLATED = 2'd2
  } iso_state_e;

endpackage

// File: rtl/axi_slice_dc_outstanding_cnt.sv
// rtl/axi_slice_dc_outstanding_cnt.sv - saturating outstanding-transaction counter with address-pending flag
module axi_slice_dc_outstanding_cnt #(
  parameter int unsigned MAX_OUTSTANDING = 16
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic                                   i_inc,
  input  logic                                   i_dec,
  input  logic                                   i_stall,
  output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   o_cnt_nxt,
  output logic                                   o_pend,
  output logic                                   o_pend_nxt,
  output logic                                   o_full
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_pend;

  always_comb begin
    o_cnt_nxt = r_cnt;
    if (i_inc && !i_dec && (r_cnt != CNT_W'(MAX_OUTSTANDING))) begin
      o_cnt_nxt = r_cnt + CNT_W'(1);
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      o_cnt_nxt = r_cnt - CNT_W'(1);
    end
  end

  // A presented-but-stalled address keeps its gate open until the handshake.
  assign o_pend_nxt = i_inc ? 1'b0 : (i_stall ? 1'b1 : r_pend);
  assign o_pend     = r_pend;
  assign o_full     = (r_cnt >= CNT_W'(MAX_OUTSTANDING));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_cnt  <= '0;
      r_pend <= 1'b0;
    end else begin
      r_cnt  <= o_cnt_nxt;
      r_pend <= o_pend_nxt;
    end
  end

  a_no_underflow : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(i_dec && !i_inc && (r_cnt == '0)));

endmodule

// File: rtl/axi_slice_dc_isolate_ctrl.sv
// rtl/axi_slice_dc_isolate_ctrl.sv - drain-and-isolate controller for the dual-clock AXI slice slave side
// Optional drain timeout: define AXI_SLICE_DC_ISO_TIMEOUT_EN.
module axi_slice_dc_isolate_ctrl
  import axi_slice_dc_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned TIMEOUT_CYCLES  = 1024
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic isolate_req_i,
  output logic isolated_o,
  output logic draining_o,
  output logic timeout_o,
  input  logic aw_valid_i,
  output logic aw_ready_o,
  output logic aw_valid_o,
  input  logic aw_ready_i,
  input  logic ar_valid_i,
  output logic ar_ready_o,
  output logic ar_valid_o,
  input  logic ar_ready_i,
  input  logic b_valid_i,
  input  logic b_ready_i,
  input  logic r_valid_i,
  input  logic r_ready_i,
  input  logic r_last_i
);

  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  if (MAX_OUTSTANDING == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("MAX_OUTSTANDING and TIMEOUT_CYCLES must be non-zero");
  end

  iso_state_e       r_state, w_state_nxt;
  logic             w_accept_aw, w_accept_ar;
  logic             w_aw_hs, w_ar_hs, w_aw_stall, w_ar_stall, w_b_hs, w_r_done;
  logic [CNT_W-1:0] w_wr_cnt_nxt, w_rd_cnt_nxt;
  logic             w_aw_pend, w_aw_pend_nxt, w_ar_pend, w_ar_pend_nxt;
  logic             w_wr_full, w_rd_full, w_drained, w_timeout_hit;

  assign w_accept_aw = ((r_state == RUN) && !w_wr_full) || w_aw_pend;
  assign w_accept_ar = ((r_state == RUN) && !w_rd_full) || w_ar_pend;
  assign aw_valid_o  = aw_valid_i & w_accept_aw;
  assign aw_ready_o  = aw_ready_i & w_accept_aw;
  assign ar_valid_o  = ar_valid_i & w_accept_ar;
  assign ar_ready_o  = ar_ready_i & w_accept_ar;

  assign w_aw_hs    = aw_valid_o & aw_ready_i;
  assign w_ar_hs    = ar_valid_o & ar_ready_i;
  assign w_aw_stall = aw_valid_o & ~aw_ready_i;
  assign w_ar_stall = ar_valid_o & ~ar_ready_i;
  assign w_b_hs     = b_valid_i & b_ready_i;
  assign w_r_done   = r_valid_i & r_ready_i & r_last_i;

  axi_slice_dc_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_inc      (w_aw_hs),
    .i_dec      (w_b_hs),
    .i_stall    (w_aw_stall),
    .o_cnt_nxt  (w_wr_cnt_nxt),
    .o_pend     (w_aw_pend),
    .o_pend_nxt (w_aw_pend_nxt),
    .o_full     (w_wr_full)
  );

  axi_slice_dc_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_inc      (w_ar_hs),
    .i_dec      (w_r_done),
    .i_stall    (w_ar_stall),
    .o_cnt_nxt  (w_rd_cnt_nxt),
    .o_pend     (w_ar_pend),
    .o_pend_nxt (w_ar_pend_nxt),
    .o_full     (w_rd_full)
  );

  // Post-update view, so isolation follows the last completion by one cycle.
  assign w_drained = (w_wr_cnt_nxt == '0) && (w_rd_cnt_nxt == '0) &&
                     !w_aw_pend_nxt && !w_ar_pend_nxt;

`ifdef AXI_SLICE_DC_ISO_TIMEOUT_EN
  localparam int unsigned TMR_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMR_W-1:0] r_tmr;
  logic             r_timeout;

  assign w_timeout_hit = (r_tmr == TMR_W'(TIMEOUT_CYCLES - 1));
  assign timeout_o     = r_timeout;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_tmr     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_tmr <= (r_state == DRAIN) ? r_tmr + TMR_W'(1) : '0;
      if ((r_state == DRAIN) && (w_state_nxt == ISOLATED) && !w_drained) begin
        r_timeout <= 1'b1;
      end
    end
  end
`else
  assign w_timeout_hit = 1'b0;
  assign timeout_o     = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      RUN:      if (isolate_req_i) w_state_nxt = DRAIN;
      DRAIN: begin
        if (!isolate_req_i)                 w_state_nxt = RUN;
        else if (w_drained || w_timeout_hit) w_state_nxt = ISOLATED;
      end
      ISOLATED: if (!isolate_req_i) w_state_nxt = RUN;
      default:  w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= RUN;
    else         r_state <= w_state_nxt;
  end

  assign isolated_o = (r_state == ISOLATED);
  assign draining_o = (r_state == DRAIN);

endmodule

// File: doc/axi_slice_dc_isolate_ctrl.md
# axi_slice_dc_isolate_ctrl

Drain-and-isolate controller for the dual-clock AXI slice slave side. It sits in the slave clock domain in front of the slice slave wrapper. It gates new AW/AR address handshakes and counts outstanding write and read transactions. On an isolation request it stops new traffic, waits for all outstanding responses, then drives the slice's `isolate_i`. This lets a power or clock domain be cut without losing or corrupting AXI responses.

## Interface
- `MAX_OUTSTANDING`, 16: maximum outstanding transactions per direction; counter width `$clog2(MAX_OUTSTANDING+1)`.
- `TIMEOUT_CYCLES`, 1024: drain timeout. Used only with `AXI_SLICE_DC_ISO_TIMEOUT_EN`.

Ports:
- `clk_i`  in  1  slave-domain clock.
- `rst_ni`  in  1  reset; asynchronous, active-low.
- `isolate_req_i`  in  1  level request to isolate.
- `isolated_o`  out  1  drives slice `isolate_i`.
- `draining_o`  out  1  high while in DRAIN.
- `timeout_o`  out  1  sticky drain-timeout flag. Tied 0 when the feature is compiled out.
- `aw_valid_i` / `aw_ready_o`  in/out  1  upstream AW handshake.
- `aw_valid_o` / `aw_ready_i`  out/in  1  downstream AW handshake to the slice.
- `ar_valid_i` / `ar_ready_o` / `ar_valid_o` / `ar_ready_i`  1  same scheme for AR.
- `b_valid_i`, `b_ready_i`  in  1  observed B handshake on the slave side.
- `r_valid_i`, `r_ready_i`, `r_last_i`  in  1  observed R handshake on the slave side.

## Operation
- FSM states are RUN, DRAIN and ISOLATED. Reset state is RUN.
- RUN → DRAIN when `isolate_req_i` is 1.
- DRAIN → RUN when `isolate_req_i` is 0. The drain is aborted.
- DRAIN → ISOLATED when all of these hold: `wr_cnt`==0, `rd_cnt`==0, `aw_pend`==0, `ar_pend`==0.
- ISOLATED → RUN when `isolate_req_i` is 0.
- `wr_cnt` tracking:
  - +1 on `aw_valid_o & aw_ready_i`.
  - −1 on `b_valid_i & b_ready_i`.
  - Both in the same cycle: unchanged.
- `rd_cnt` tracking:
  - +1 on AR handshake.
  - −1 on an R handshake with `r_last_i`=1.
  - Both in the same cycle: unchanged.
- Pending flags:
  - `aw_pend` is set when `aw_valid_o & ~aw_ready_i`.
  - `aw_pend` is cleared on the AW handshake.
  - `ar_pend` works the same way for AR.
- Gating:
  - `accept_aw = (state==RUN & wr_cnt<MAX_OUTSTANDING) | aw_pend`.
  - `aw_valid_o = aw_valid_i & accept_aw`.
  - `aw_ready_o = aw_ready_i & accept_aw`.
  - AR is gated identically.
  - The pending term keeps an already-presented valid asserted until accepted, so the AXI valid-stability rule holds.
- W channel is not gated. It belongs to AW transactions already accepted.
- Outputs: `isolated_o` = (state==ISOLATED); `draining_o` = (state==DRAIN).
- A decrement at count 0 is a protocol error. It is flagged by assertion only; the counter saturates at 0.

## Timing
- Reset values: all outputs 0, counters 0, pend flags 0, state RUN.
- `isolate_req_i` rising at cycle N: `draining_o`=1 at N+1, and address gating is closed from N+1.
- Already drained: `isolated_o`=1 at N+2.
- Last B/R completion handshake at cycle M: `isolated_o`=1 at M+1.
- Request released in ISOLATED at cycle K: `isolated_o`=0 and gating reopens at K+1.
- Counter at MAX: the AW handshake is blocked the cycle after it reaches MAX. A B in the same cycle as a full-count AW attempt does not open the gate until the next cycle.
- Reset mid-DRAIN: immediate return to RUN with counts cleared.

## Configuration
- `AXI_SLICE_DC_ISO_TIMEOUT_EN` defined:
  - A cycle counter runs in DRAIN.
  - After `TIMEOUT_CYCLES` cycles in DRAIN, the FSM enters ISOLATED regardless of counts and sets `timeout_o`.
  - `timeout_o` clears only on reset.
- Undefined: no timer, `timeout_o`=0, and DRAIN may last indefinitely.

## Structure
- Package `axi_slice_dc_pkg` holds the `iso_state_e` enum (RUN, DRAIN, ISOLATED).
- Sub-module `axi_slice_dc_outstanding_cnt` contains the up/down counter with saturation and the pending flag. It is instantiated once for write and once for read.

## Test plan
- Idle, `isolate_req_i`=1 at cycle 10 → `draining_o`=1 at 11, `isolated_o`=1 at 12.
- 3 AW accepted, no B; request isolation → stays in DRAIN. Send 3 B → `isolated_o`=1 one cycle after the third B.
- `aw_valid_i`=1 with `aw_ready_i`=0 when the request arrives → `aw_valid_o` held until accepted, then the count is drained before ISOLATED.
- 16 AR accepted with `MAX_OUTSTANDING`=16 → 17th AR blocked (`ar_ready_o`=0). One R last → 17th accepted the following cycle.
- Simultaneous AW handshake and B handshake at `wr_cnt`=5 → `wr_cnt` stays 5. Request dropped mid-DRAIN → RUN next cycle.
- With `AXI_SLICE_DC_ISO_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8: 1 outstanding read, no R → `isolated_o`=1 and `timeout_o`=1 after 8 DRAIN cycles.
